shift_result_stage: RTL
=======================

Name: shift_result_stage

Overview:
Registered output stage directly downstream of the combinational barrel shifter. It captures the shifter result and flags (y, negative, zero, cout, overflow) under a valid/ready handshake and buffers them in a 2-entry skid buffer. This breaks the combinational path from shifter to consumer (register file writeback / flag register). It also keeps a sticky overflow flag and a count of delivered results.

Parameters:
WIDTH, 16, datapath width; must match the upstream shifter WIDTH.
CNT_WIDTH, 16, width of the delivered-result counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream shifter result is valid this cycle.
in_ready  output  1  stage can accept a result this cycle.
in_y  input  WIDTH  shifter result.
in_negative  input  1  shifter N flag.
in_zero  input  1  shifter Z flag.
in_cout  input  1  shifter C flag.
in_overflow  input  1  shifter V flag.
out_valid  output  1  out_y/out_flags hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
out_y  output  WIDTH  buffered result.
out_flags  output  4  {N,Z,C,V} of the buffered result.
sticky_v  output  1  set when any accepted result had V=1.
sticky_clr  input  1  synchronous clear of sticky_v.
out_count  output  CNT_WIDTH  number of output handshakes since reset, modulo 2^CNT_WIDTH.

Behaviour:
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register. Both hold {y, N, Z, C, V}.
- State machine: EMPTY, ONE, FULL.
  - EMPTY: accept -> load main, go to ONE.
  - ONE, accept & deliver -> load main with input, stay ONE.
  - ONE, accept & no deliver -> load skid, go to FULL.
  - ONE, deliver & no accept -> go to EMPTY.
  - FULL, deliver -> move skid to main, go to ONE. No accept is possible in FULL.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. in_ready is a registered state decode and has no combinational path from out_ready.
- out_valid = 1 in ONE and FULL.
- Latency: a result accepted at edge k appears on out_y/out_valid after edge k (one cycle).
- Ordering is strictly FIFO. No result is dropped or duplicated.
- out_y and out_flags hold stable while out_valid=1 and out_ready=0.
- Values in an empty entry are don't-care but reset to 0.
- sticky_v:
  - Set on the cycle after an accept with in_overflow=1.
  - sticky_clr=1 clears it on the next edge.
  - If a set and sticky_clr occur on the same edge, set wins (sticky_v=1).
- out_count:
  - Increments by 1 on each deliver.
  - Wraps from all-ones to 0.
  - Not affected by accepts.
- Flags pass through unmodified. This stage does not recompute N/Z/C/V from y.
- Reset (rst_n=0, any time, including mid-transfer or while FULL):
  - State -> EMPTY, out_valid=0, in_ready=1.
  - out_y=0, out_flags=4'b0000, sticky_v=0, out_count=0.
  - Buffered entries are discarded.
  - Outputs take reset values immediately, independent of clk.
- After rst_n deasserts, the first edge may accept.

Test Plan:
1. Reset, then single transfer: in_y=16'h8001, flags N=1,Z=0,C=0,V=0, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_y=16'h8001, out_flags=4'b1000. Following cycle out_valid=0, out_count=1.
2. Back-pressure/skid: out_ready=0, stream 16'h0001, 16'h0002, 16'h0003 with in_valid=1 -> first two accepted, in_ready=0 after the second. Raise out_ready -> outputs 0001, 0002, 0003 in order with no loss; out_count=3.
3. Full throughput: in_valid=1, out_ready=1 for 20 cycles with incrementing data -> one result per cycle, in_ready stays 1, out_count=20, output equals input delayed one cycle.
4. Sticky: accept a result with V=1, then results with V=0 -> sticky_v=1 persists. Pulse sticky_clr on the same edge as another V=1 accept -> sticky_v stays 1. Pulse sticky_clr alone -> sticky_v=0.
5. Async reset mid-operation: while FULL with out_ready=0, assert rst_n=0 between clock edges -> out_valid=0, out_y=0, in_ready=1, sticky_v=0, out_count=0 without a clock edge. The buffered data is never delivered.
6. Counter wrap (CNT_WIDTH=4 override): 17 delivers -> out_count reads 0xF after 15 and 0x1 after 17.

Source files
------------

// File: rtl/shift_result_stage_if.sv
// Handshake bundle between the barrel shifter, this result stage and the
// downstream consumer (register file writeback / flag register).
//
// Upstream side : in_valid, in_ready, in_y, in_negative, in_zero, in_cout,
//                 in_overflow
// Downstream side: out_valid, out_ready, out_y, out_flags {N,Z,C,V}
//
// master : the environment around the stage (drives in_*, out_ready)
// slave  : the result stage itself
interface shift_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_negative;
  logic             in_zero;
  logic             in_cout;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_y, in_negative, in_zero, in_cout, in_overflow,
    output out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, in_y, in_negative, in_zero, in_cout, in_overflow,
    input  out_ready,
    output in_ready, out_valid, out_y, out_flags
  );
endinterface

// File: rtl/shift_result_stage.sv
// Registered output stage behind the combinational barrel shifter.
// Captures {y, N, Z, C, V} under a valid/ready handshake into a 2-entry
// skid buffer so the consumer never sees the shifter's combinational path.
// Also keeps a sticky overflow flag and a count of delivered results.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sif        handshake bundle (slave side): in_* from shifter, out_* to
//              consumer; out_flags = {N,Z,C,V}
//   sticky_clr synchronous clear of sticky_v (a same-edge set wins)
//   sticky_v   set once any accepted result carried V=1
//   out_count  number of delivered results since reset, wrapping
module shift_result_stage #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_result_stage_if.slave  sif,
  input  logic                 sticky_clr,
  output logic                 sticky_v,
  output logic [CNT_WIDTH-1:0] out_count
);

  // Each entry is {y, N, Z, C, V}; flags sit in the low four bits.
  localparam int EW = WIDTH + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          next_state;
  logic [EW-1:0]   main_q;
  logic [EW-1:0]   skid_q;
  logic [EW-1:0]   in_entry;
  logic            accept;
  logic            deliver;
  logic            load_main_in;
  logic            load_skid;
  logic            move_skid;

  assign in_entry = {sif.in_y, sif.in_negative, sif.in_zero,
                     sif.in_cout, sif.in_overflow};

  // in_ready is a pure decode of the state register, so out_ready never
  // reaches the upstream side combinationally.
  assign sif.in_ready  = (state_q != FULL);
  assign sif.out_valid = (state_q != EMPTY);
  assign sif.out_y     = main_q[EW-1:4];
  assign sif.out_flags = main_q[3:0];

  assign accept  = sif.in_valid  & sif.in_ready;
  assign deliver = sif.out_valid & sif.out_ready;

  // Next-state and datapath steering. The skid entry is only ever filled
  // when main is occupied and not draining, and is only emptied into main.
  always_comb begin
    next_state   = state_q;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (deliver) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          move_skid  = 1'b1;
          next_state = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // State and storage registers; reset discards any buffered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= next_state;
      if (load_main_in) main_q <= in_entry;
      else if (move_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_entry;
    end
  end

  // Sticky overflow: a new V=1 accept beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v <= 1'b0;
    end else if (accept && sif.in_overflow) begin
      sticky_v <= 1'b1;
    end else if (sticky_clr) begin
      sticky_v <= 1'b0;
    end
  end

  // Delivered-result counter, free-running modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (deliver) begin
      out_count <= out_count + 1'b1;
    end
  end

endmodule
